// File: rtl/temporizador_descendente_pkg.sv
// Shared types for the down-counting timer: FSM state encoding and default sizes.
package temporizador_descendente_pkg;

  // Encoding 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } tmr_state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/temporizador_descendente_if.sv
// Command/status bundle between the sequencer (master) and the timer (slave).
interface temporizador_descendente_if #(
  parameter int WIDTH = 8
);
  // No valid/ready pair: start/stop are level commands sampled on every rising
  // edge (stop always wins), load_val is taken on an accepted start, auto_reload
  // on the terminal edge; out/busy/done are registered, zero is combinational.
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load_val, start, stop, auto_reload,
    input  out, busy, done, zero
  );

  modport slave (
    input  load_val, start, stop, auto_reload,
    output out, busy, done, zero
  );
endinterface

// File: rtl/temporizador_descendente_divisor_tick.sv
// Prescaler: emits one tick every PRESCALE enabled cycles; phase survives en=0.
module divisor_tick #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rstn, clr};
      assign tick     = en;
    end else begin : g_div
      localparam int            CW   = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] r_cnt;

      // clr outranks en so a reload restarts the phase even while running
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
      end

      assign tick = en && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/temporizador_descendente.sv
// Loadable down-counting timer with pause/resume, retrigger and optional auto-reload.
module temporizador_descendente
  import temporizador_descendente_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                              clk,
  input  logic                              rstn,
  temporizador_descendente_if.slave         bus,
  output tmr_state_t                        o_dbg_state
);

  tmr_state_t       r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_en;
  logic w_tick;

  // A load is accepted from IDLE or RUN; in PAUSE the same command means resume.
  assign w_load = bus.start && !bus.stop && (r_state != ST_PAUSE);
  assign w_en   = (r_state == ST_RUN) && !bus.stop;

  divisor_tick #(
    .PRESCALE (PRESCALE)
  ) u_divisor_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (w_en),
    .clr  (w_load),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_out    <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.stop) begin
            r_state <= ST_PAUSE;
          end else if (bus.start) begin
            if (bus.load_val == '0) begin
              r_out   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_out    <= bus.load_val;
              r_reload <= bus.load_val;
            end
          end else if (w_tick) begin
            // The 1 -> 0 step belongs to the terminal logic, never to a plain decrement.
            if (r_out == WIDTH'(1)) begin
              r_done <= 1'b1;
              if (bus.auto_reload) begin
                r_out <= r_reload;
              end else begin
                r_out   <= '0;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else if (r_out != '0) begin
              r_out <= r_out - 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.start) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          if (bus.start && !bus.stop) begin
            if (bus.load_val == '0) begin
              r_out  <= '0;
              r_done <= 1'b1;
            end else begin
              r_out    <= bus.load_val;
              r_reload <= bus.load_val;
              r_state  <= ST_RUN;
              r_busy   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.out     = r_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.zero    = (r_out == '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_temporizador_descendente.sv
// Bench for temporizador_descendente: PRESCALE=1 and PRESCALE=4 instances share one stimulus stream.
module tb_temporizador_descendente;
  import temporizador_descendente_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic         ar    = 1'b0;
  logic [W-1:0] lv    = '0;

  temporizador_descendente_if #(.WIDTH(W)) if1 ();
  temporizador_descendente_if #(.WIDTH(W)) if4 ();
  tmr_state_t dbg1, dbg4;

  assign if1.start = start;  assign if1.stop = stop;
  assign if1.auto_reload = ar;  assign if1.load_val = lv;
  assign if4.start = start;  assign if4.stop = stop;
  assign if4.auto_reload = ar;  assign if4.load_val = lv;

  temporizador_descendente #(.WIDTH(W), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(if1.slave), .o_dbg_state(dbg1)
  );
  temporizador_descendente #(.WIDTH(W), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .bus(if4.slave), .o_dbg_state(dbg4)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 counting, 2 paused; ph counts enabled cycles within one decrement period.
  int   m_mode[2], m_ph[2], m_out[2], m_rel[2];
  logic m_done[2];

  function automatic int ps(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_ph[d] = 0; m_out[d] = 0; m_rel[d] = 0; m_done[d] = 1'b0;
    end
  endtask

  task automatic model_step(int d);
    m_done[d] = 1'b0;
    if (m_mode[d] == 2) begin
      if (stop) m_mode[d] = 0;
      else if (start) m_mode[d] = 1;
    end else if (m_mode[d] == 1 && stop) begin
      m_mode[d] = 2;
    end else if (start && !stop) begin
      if (lv == 0) begin
        m_out[d] = 0; m_done[d] = 1'b1; m_mode[d] = 0;
      end else begin
        m_out[d] = int'(lv); m_rel[d] = int'(lv); m_ph[d] = 0; m_mode[d] = 1;
      end
    end else if (m_mode[d] == 1) begin
      m_ph[d] = m_ph[d] + 1;
      if (m_ph[d] == ps(d)) begin
        m_ph[d] = 0;
        if (m_out[d] == 1) begin
          m_done[d] = 1'b1;
          if (ar) m_out[d] = m_rel[d];
          else begin m_out[d] = 0; m_mode[d] = 0; end
        end else begin
          m_out[d] = m_out[d] - 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("sb_out_p1", int'(if1.out), int'(e));
    check("busy_p1", int'(if1.busy), int'(m_mode[0] != 0));
    check("done_p1", int'(if1.done), int'(m_done[0]));
    check("zero_p1", int'(if1.zero), int'(m_out[0] == 0));
    check("out_p4",  int'(if4.out),  m_out[1]);
    check("busy_p4", int'(if4.busy), int'(m_mode[1] != 0));
    check("done_p4", int'(if4.done), int'(m_done[1]));
    check("zero_p4", int'(if4.zero), int'(m_out[1] == 0));
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_step(0);
    model_step(1);
    exp_q.push_back(W'(m_out[0]));
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_in(logic s, logic p, logic a, logic [W-1:0] v);
    start = s; stop = p; ar = a; lv = v;
  endtask

  task automatic go_idle();
    set_in(1'b0, 1'b1, 1'b0, '0);
    cycle();
    cycle();
    stop = 1'b0;
  endtask

  typedef struct {
    logic         st;
    logic         sp;
    logic [W-1:0] lv;
    logic [W-1:0] e_out;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n, first_dec;
    logic [W-1:0] prev;
    int seq4[4];

    // PRESCALE=1 expectations written straight from the timer's rules.
    tbl[0]  = '{1'b1, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'd7, 8'd7, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'd0, 8'd7, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'd0, 8'd7, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'd9, 8'd7, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};

    // Power-on reset
    model_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_out_p1", int'(if1.out), 0);
    check("rst_busy_p1", int'(if1.busy), 0);
    check("rst_done_p4", int'(if4.done), 0);
    @(negedge clk) rstn = 1'b1;

    // Table-driven basic sequences
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].st, tbl[i].sp, 1'b0, tbl[i].lv);
      cycle();
      check($sformatf("tbl_out[%0d]", i), int'(if1.out), int'(tbl[i].e_out));
      check($sformatf("tbl_busy[%0d]", i), int'(if1.busy), int'(tbl[i].e_busy));
      check($sformatf("tbl_done[%0d]", i), int'(if1.done), int'(tbl[i].e_done));
    end
    set_in(1'b0, 1'b0, 1'b0, '0);

    // PRESCALE=4, load 2: done 8 edges after the start edge, first decrement at edge 4
    go_idle();
    set_in(1'b1, 1'b0, 1'b0, 8'd2);
    cycle();
    start = 1'b0;
    n = 0; first_dec = -1; prev = if4.out;
    while (n < 40 && !if4.done) begin
      cycle();
      n++;
      if (first_dec < 0 && if4.out != prev) first_dec = n;
    end
    check("p4_done_edges", n, 8);
    check("p4_first_dec", first_dec, 4);

    // Pause at 4 for five cycles, resume without reload
    go_idle();
    set_in(1'b1, 1'b0, 1'b0, 8'd6);
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check("t4_at4", int'(if1.out), 4);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (4) cycle();
    check("t4_held", int'(if1.out), 4);
    check("t4_busy", int'(if1.busy), 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("t4_resume", int'(if1.out), 4);
    seq4 = '{3, 2, 1, 0};
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("t4_seq[%0d]", k), int'(if1.out), seq4[k]);
      check($sformatf("t4_done[%0d]", k), int'(if1.done), int'(k == 3));
    end

    // Auto-reload of 2
    go_idle();
    set_in(1'b1, 1'b0, 1'b1, 8'd2);
    cycle();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check($sformatf("ar_out[%0d]", k), int'(if1.out), (k % 2 == 1) ? 1 : 2);
      check($sformatf("ar_done[%0d]", k), int'(if1.done), int'(k % 2 == 0));
      check($sformatf("ar_busy[%0d]", k), int'(if1.busy), 1);
    end
    set_in(1'b1, 1'b1, 1'b1, 8'd5);
    cycle();
    check("ar_pause_state", int'(dbg1), int'(ST_PAUSE));
    set_in(1'b0, 1'b1, 1'b0, '0);
    cycle();
    check("ar_abort_state", int'(dbg1), int'(ST_IDLE));
    stop = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      set_in(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) == 0),
             logic'($urandom_range(0, 3) == 0), W'($urandom_range(0, 6)));
      cycle();
    end

    // Asynchronous reset in the middle of a count
    go_idle();
    set_in(1'b1, 1'b0, 1'b0, 8'd5);
    cycle();
    start = 1'b0;
    check("mid_out_p1", int'(if1.out), 5);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_p1", int'(if1.out), 0);
    check("arst_busy_p1", int'(if1.busy), 0);
    check("arst_done_p1", int'(if1.done), 0);
    check("arst_out_p4", int'(if4.out), 0);
    check("arst_busy_p4", int'(if4.busy), 0);
    model_reset();
    @(negedge clk) rstn = 1'b1;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
